// File: rtl/pipeline_scheduler_if.sv
// Decode-to-scheduler signal bundle for pipeline_scheduler.
// Handshake: decode presents an instruction with d_valid=1. The scheduler
// accepts it on any rising edge where stall_d=0; while stall_d=1 decode must
// hold every d_* field stable. stall_d acts as the inverted ready. A taken
// branch (br_taken) squashes the instruction in flight (flush_d and flush_ex),
// whatever the state of that handshake.
interface pipeline_scheduler_if #(
  parameter int regSelBits = 4
);
  logic                  d_valid;
  logic [regSelBits-1:0] d_rs1;
  logic                  d_rs1_used;
  logic [regSelBits-1:0] d_rs2;
  logic                  d_rs2_used;
  logic [regSelBits-1:0] d_rd;
  logic                  d_wr_en;
  logic                  br_taken;
  logic                  stall_f;
  logic                  stall_d;
  logic                  bubble_ex;
  logic                  flush_d;
  logic                  flush_ex;
  logic [1:0]            state;
  logic [15:0]           stall_cnt;

  // Pipeline side: drives the decode fields and the branch, and sees the controls.
  modport master (
    output d_valid, d_rs1, d_rs1_used, d_rs2, d_rs2_used, d_rd, d_wr_en, br_taken,
    input  stall_f, stall_d, bubble_ex, flush_d, flush_ex, state, stall_cnt
  );

  // Scheduler side.
  modport slave (
    input  d_valid, d_rs1, d_rs1_used, d_rs2, d_rs2_used, d_rd, d_wr_en, br_taken,
    output stall_f, stall_d, bubble_ex, flush_d, flush_ex, state, stall_cnt
  );
endinterface

// File: rtl/pipeline_scheduler.sv
// Hazard scheduler. A register scoreboard of write-back down-counters finds
// RAW hazards. A RUN/STALL/FLUSH FSM tracks the squash window that follows a
// taken branch. A saturating counter counts the stall cycles.
module pipeline_scheduler #(
  parameter int regSelBits = 4,
  parameter int wbLatency  = 2,
  parameter int flushLen   = 2
) (
  input  logic                clk,
  input  logic                rst,
  pipeline_scheduler_if.slave bus
);
  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  localparam int numRegs = 1 << regSelBits;
  localparam int sbW     = (wbLatency > 0) ? $clog2(wbLatency + 1) : 1;
  localparam int fcW     = (flushLen > 1) ? $clog2(flushLen) : 1;
  localparam logic [sbW-1:0] sbLoad = sbW'(wbLatency);
  localparam logic [fcW-1:0] fcLoad = fcW'(flushLen - 1);

  state_t         stateQ, stateD;
  logic [fcW-1:0] flushCntQ, flushCntD;
  logic [sbW-1:0] sb [numRegs];
  logic [15:0]    stallCntQ;

  logic hazard;
  logic flushD;
  logic stallD;
  logic issue;

  // A source is pending while its destination counter has not yet drained to zero.
  always_comb begin
    hazard = bus.d_valid &
             ((bus.d_rs1_used & (sb[bus.d_rs1] != '0)) |
              (bus.d_rs2_used & (sb[bus.d_rs2] != '0)));
    flushD = bus.br_taken | (stateQ == FLUSH);
    // A flush has priority: a squashed instruction is never held.
    stallD = hazard & ~flushD;
    issue  = bus.d_valid & bus.d_wr_en & ~stallD & ~flushD;
  end

  assign bus.flush_ex  = bus.br_taken;
  assign bus.flush_d   = flushD;
  assign bus.stall_d   = stallD;
  assign bus.stall_f   = stallD;
  assign bus.bubble_ex = stallD;
  assign bus.state     = stateQ;
  assign bus.stall_cnt = stallCntQ;

  // State register and flush-window counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= RUN;
      flushCntQ <= '0;
    end else begin
      stateQ    <= stateD;
      flushCntQ <= flushCntD;
    end
  end

  // Next-state logic. A new branch always restarts the squash window.
  always_comb begin
    stateD    = stateQ;
    flushCntD = flushCntQ;
    case (stateQ)
      RUN: begin
        if (bus.br_taken) begin
          stateD    = FLUSH;
          flushCntD = fcLoad;
        end else if (hazard) begin
          stateD = STALL;
        end
      end
      STALL: begin
        if (bus.br_taken) begin
          stateD    = FLUSH;
          flushCntD = fcLoad;
        end else if (!hazard) begin
          stateD = RUN;
        end
      end
      FLUSH: begin
        if (bus.br_taken) begin
          flushCntD = fcLoad;
        end else if (flushCntQ != '0) begin
          flushCntD = flushCntQ - 1'b1;
        end else if (hazard) begin
          stateD = STALL;
        end else begin
          stateD = RUN;
        end
      end
      default: begin
        stateD    = RUN;
        flushCntD = '0;
      end
    endcase
  end

  // Scoreboard: an issue reloads its destination (WAW included), and every other entry drains.
  // Branches leave the scoreboard alone. Writers that were killed only cost extra stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < numRegs; i++) sb[i] <= '0;
    end else begin
      for (int i = 0; i < numRegs; i++) begin
        if (issue && (bus.d_rd == regSelBits'(i))) sb[i] <= sbLoad;
        else if (sb[i] != '0)                      sb[i] <= sb[i] - 1'b1;
      end
    end
  end

  // Stall-cycle performance counter, which saturates at all ones.
  always_ff @(posedge clk) begin
    if (rst)                                  stallCntQ <= '0;
    else if (stallD && stallCntQ != 16'hFFFF) stallCntQ <= stallCntQ + 16'd1;
  end
endmodule

// File: doc/pipeline_scheduler.md
PIPELINE_SCHEDULER -- requirements
Module: pipeline_scheduler

Interface
REQ-001 SHALL have parameter regSelBits, default 4, register select width (bit 3 = vector bank, bits 2:0 = index).
REQ-002 SHALL have parameter wbLatency, default 2, cycles from issue until the destination register is readable by decode.
REQ-003 SHALL have parameter flushLen, default 2, cycles decode is squashed after a taken PC write.
REQ-004 SHALL have a single clock; reset is synchronous and active-high. Ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL have d_valid input 1, decode stage holds a valid instruction.
REQ-006 SHALL have d_rs1 input regSelBits and d_rs1_used input 1, first source select and its use flag.
REQ-007 SHALL have d_rs2 input regSelBits and d_rs2_used input 1, second source select and its use flag.
REQ-008 SHALL have d_rd input regSelBits and d_wr_en input 1, destination select and write flag (scalar or vector write enable).
REQ-009 SHALL have br_taken input 1, PC write enable from the memory stage.
REQ-010 SHALL have stall_f output 1 (hold PC) and stall_d output 1 (hold the fetch/decode pipe).
REQ-011 SHALL have bubble_ex output 1, insert NOP into the decode/execute pipe.
REQ-012 SHALL have flush_d output 1 and flush_ex output 1, squash decode and execute contents.
REQ-013 SHALL have state output 2 (RUN=00, STALL=01, FLUSH=10) and stall_cnt output 16 (performance counter).

Function
REQ-014 SHALL keep a scoreboard of 2^regSelBits down-counters, each ceil(log2(wbLatency+1)) bits wide.
REQ-015 SHALL compute hazard = d_valid & ((d_rs1_used & sb[d_rs1]!=0) | (d_rs2_used & sb[d_rs2]!=0)) combinationally.
REQ-016 SHALL compute issue = d_valid & d_wr_en & ~stall_d & ~flush_d.
REQ-017 SHALL, each cycle, decrement every nonzero scoreboard entry by 1 with no wrap below 0.
REQ-018 SHALL load sb[d_rd] = wbLatency on issue; this load overrides the decrement of that entry (WAW reloads).
REQ-019 SHALL drive flush_ex = br_taken and flush_d = br_taken | (state==FLUSH), both combinationally.
REQ-020 SHALL drive stall_f = stall_d = bubble_ex = hazard & ~flush_d; flush has priority over a hazard stall.
REQ-021 SHALL run the FSM from RUN: br_taken -> FLUSH (load counter flushLen-1); else hazard -> STALL; else stay in RUN.
REQ-022 SHALL, from STALL: br_taken -> FLUSH; hazard -> stay in STALL; else -> RUN.
REQ-023 SHALL, in FLUSH: decrement the counter; br_taken reloads flushLen-1; at counter 0 with no br_taken, go to RUN if no hazard, else STALL.
REQ-024 SHALL leave the scoreboard untouched by br_taken; killed execute-stage writers leave entries that only cause conservative stalls.
REQ-025 SHALL increment stall_cnt on each cycle stall_d=1, saturating at 16'hFFFF.
REQ-026 SHALL never assert stall_d when d_valid=0.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set state=RUN, clear the flush counter, clear all scoreboard entries, and set stall_cnt=0.
REQ-028 SHALL give rst priority over br_taken, issue, and decrement; with rst held, all outputs read 0 after the edge (combinational outputs follow from cleared state when d_valid=0 and br_taken=0).
REQ-029 SHALL, if reset arrives mid-stall or mid-flush, resume in RUN with no residual hazard on the next cycle.

Verification
REQ-030 RAW: issue rd=3, then next instruction reads rs1=3 -> stall_d=1 for 2 cycles, state=STALL, stall_cnt=2, proceeds in the 3rd cycle.
REQ-031 Independent: issue rd=3, then read rs1=5, rs2=9 -> no stall, state stays RUN.
REQ-032 Branch: br_taken pulse at cycle t -> flush_ex=1 at t only; flush_d=1 at t, t+1, t+2; state=FLUSH at t+1, t+2; RUN at t+3.
REQ-033 Hazard concurrent with br_taken: rs1 pending and br_taken=1 in the same cycle -> stall_d=0, flush_d=1, no issue.
REQ-034 Saturation: hold a hazard by forcing stall_cnt near 16'hFFFE via a long stall -> counter stops at 16'hFFFF.
REQ-035 Reset mid-stall: pending sb[3]=2 with a hazard active, assert rst -> next cycle state=RUN, stall_d=0, stall_cnt=0.
